// File: rtl/status_strobe.sv
// rtl/status_strobe.sv - multi-channel GPIO indicator driver (off / on / heartbeat / event pulse-stretch)
// Optional STATUS_STROBE_SYNC_EN: two-flop synchroniser on every event_i bit.
module status_strobe #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 27,
  parameter int HOLD_W      = 24,
  parameter int HOLD_CYCLES = 10_000_000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [2*CHANNELS-1:0] mode_i,
  input  logic [CHANNELS-1:0]   event_i,
  output logic [CHANNELS-1:0]   strobe,
  output logic                  tick
);

  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  logic [CNT_W-1:0]    r_prescaler;
  logic                r_tick;
  logic                w_heartbeat;
  logic [CHANNELS-1:0] w_event;
  logic [CHANNELS-1:0] r_strobe;

  assign w_heartbeat = r_prescaler[CNT_W-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_prescaler <= '0;
      r_tick      <= 1'b0;
    end else begin
      r_prescaler <= r_prescaler + CNT_W'(1);
      r_tick      <= (r_prescaler == CNT_MAX);
    end
  end

`ifdef STATUS_STROBE_SYNC_EN
  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= event_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_event = r_sync2;
`else
  assign w_event = event_i;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [HOLD_W-1:0] r_hold;
    logic              w_stretch;
    logic              w_strobe_nxt;

    // Stretch covers the event edge itself plus the remaining hold count.
    assign w_stretch = w_event[g] | (r_hold != '0);

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_hold <= '0;
      end else if (w_event[g]) begin
        r_hold <= HOLD_RELOAD;
      end else if (r_hold != '0) begin
        r_hold <= r_hold - HOLD_W'(1);
      end
    end

    always_comb begin
      w_strobe_nxt = 1'b0;
      case (mode_i[2*g +: 2])
        2'b00:   w_strobe_nxt = 1'b0;
        2'b01:   w_strobe_nxt = 1'b1;
        2'b10:   w_strobe_nxt = w_heartbeat;
        default: w_strobe_nxt = w_stretch;
      endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_strobe[g] <= 1'b0;
      end else begin
        r_strobe[g] <= w_strobe_nxt;
      end
    end
  end

  assign strobe = r_strobe;
  assign tick   = r_tick;

endmodule

// File: tb/tb_status_strobe.sv
// tb/tb_status_strobe.sv - self-checking bench for status_strobe (honours STATUS_STROBE_SYNC_EN)
module tb_status_strobe;

  localparam int CH = 4;
  localparam int HC = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [2*CH-1:0] mode_i = '0;
  logic [CH-1:0] event_i = '0;
  logic [CH-1:0] strobe;
  logic          tick;

  status_strobe #(.CHANNELS(CH), .CNT_W(4), .HOLD_W(4), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .resetn(resetn), .mode_i(mode_i), .event_i(event_i),
    .strobe(strobe), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] strobe;
    logic          tick;
  } exp_t;

  typedef struct {
    logic [CH-1:0] ev;
    logic          exp_ns;
    logic          exp_s;
  } vec_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  logic [3:0]    m_pre;
  int            m_hold[CH];
  logic [CH-1:0] m_s1, m_s2;

  localparam logic [7:0] MODES_ALL = 8'b11_10_01_00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pre = '0;
    m_s1 = '0;
    m_s2 = '0;
    for (int c = 0; c < CH; c++) m_hold[c] = 0;
    q.delete();
  endtask

  task automatic model_step(input logic [2*CH-1:0] mode, input logic [CH-1:0] ev);
    exp_t          e;
    logic          hb;
    logic          st;
    logic [CH-1:0] ev_eff;
    hb = m_pre[3];
    e.tick = (m_pre == 4'hF);
    m_pre = m_pre + 4'd1;
`ifdef STATUS_STROBE_SYNC_EN
    ev_eff = m_s2;
    m_s2 = m_s1;
    m_s1 = ev;
`else
    ev_eff = ev;
`endif
    for (int c = 0; c < CH; c++) begin
      st = ev_eff[c] || (m_hold[c] != 0);
      if (ev_eff[c]) m_hold[c] = HC - 1;
      else if (m_hold[c] != 0) m_hold[c] = m_hold[c] - 1;
      case (mode[2*c +: 2])
        2'b00:   e.strobe[c] = 1'b0;
        2'b01:   e.strobe[c] = 1'b1;
        2'b10:   e.strobe[c] = hb;
        default: e.strobe[c] = st;
      endcase
    end
    q.push_back(e);
  endtask

  task automatic cycle(input logic [2*CH-1:0] mode, input logic [CH-1:0] ev);
    exp_t e;
    mode_i = mode;
    event_i = ev;
    model_step(mode, ev);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk("sb_strobe", 32'(strobe), 32'(e.strobe));
      chk("sb_tick", 32'(tick), 32'(e.tick));
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    mode_i = '0;
    event_i = '0;
    @(posedge clk);
    #1;
    chk("rst_strobe", 32'(strobe), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  function automatic logic pick(input logic ns, input logic s);
`ifdef STATUS_STROBE_SYNC_EN
    return s;
`else
    return ns;
`endif
  endfunction

  vec_t tbl[12];

  initial begin
    // Edges 1..12: events on channel 3 at edges 5 and 7, all four modes active.
    for (int i = 0; i < 12; i++) begin
      tbl[i].ev     = (i == 4 || i == 6) ? 4'b1000 : 4'b0000;
      tbl[i].exp_ns = (i >= 4 && i <= 8);
      tbl[i].exp_s  = (i >= 6 && i <= 10);
    end

    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(MODES_ALL, tbl[i].ev);
      chk("tbl_s3", 32'(strobe[3]), 32'(pick(tbl[i].exp_ns, tbl[i].exp_s)));
      chk("tbl_s0", 32'(strobe[0]), 32'd0);
      chk("tbl_s1", 32'(strobe[1]), 32'd1);
    end
    for (int k = 13; k <= 36; k++) begin
      cycle(MODES_ALL, 4'b0000);
      chk("hb_s2", 32'(strobe[2]), 32'(((k - 1) % 16) >= 8));
      chk("tick16", 32'(tick), 32'(k % 16 == 0));
    end

    do_reset();
    for (int k = 1; k <= 10; k++) begin
      cycle(MODES_ALL, (k == 5) ? 4'b1000 : 4'b0000);
      chk("single_s3", 32'(strobe[3]), 32'(pick(k >= 5 && k <= 7, k >= 7 && k <= 9)));
    end

    do_reset();
    for (int k = 1; k <= 10; k++) begin
      cycle({(k >= 7) ? 2'b11 : 2'b00, 6'b10_01_00}, (k == 5) ? 4'b1000 : 4'b0000);
      chk("modesw_s3", 32'(strobe[3]), 32'(pick(k == 7, k >= 7 && k <= 9)));
    end

    do_reset();
    for (int k = 1; k <= 6; k++) cycle(8'hFF, (k == 5) ? 4'b1111 : 4'b0000);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_strobe", 32'(strobe), 32'd0);
    chk("async_rst_tick", 32'(tick), 32'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cycle(8'hFF, 4'b0000);
      chk("post_rst_s", 32'(strobe), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
